// File: rtl/cochlea_scan_pkg.sv
// Shared definitions for the cochlea event scanner: register map offsets,
// CTRL/STATUS bit positions and the window FSM state encoding.
package cochlea_scan_pkg;

    localparam logic [7:0] REG_CTRL        = 8'h00;
    localparam logic [7:0] REG_WINDOW      = 8'h04;
    localparam logic [7:0] REG_STATUS      = 8'h08;
    localparam logic [7:0] REG_MASK        = 8'h0C;
    localparam logic [7:0] REG_RESULT_BASE = 8'h40;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_ABORT  = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/cochlea_chan_counter.sv
// One spike channel: 2-flop synchroniser, rising-edge detect and a CW-bit
// event counter. Wraps by default; saturates at all-ones when
// COCHLEA_CNT_SAT_EN is defined. o_ovf pulses on an event that arrives
// while the counter is already all-ones (the wrap / first-saturation point).
module cochlea_chan_counter
    import cochlea_scan_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_spike,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_ovf
);

    logic          r_s1, r_s2, r_prev;
    logic [CW-1:0] r_cnt;
    logic          w_evt, w_full;

    assign w_evt  = r_s2 & ~r_prev;
    assign w_full = &r_cnt;
    assign o_ovf  = i_en & w_evt & w_full & ~i_clr;
    assign o_cnt  = r_cnt;

    // Bring the asynchronous spike into the clock domain and keep the previous sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_spike;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Count rising edges while enabled; clear has priority.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && w_evt) begin
`ifdef COCHLEA_CNT_SAT_EN
            if (!w_full) r_cnt <= r_cnt + CW'(1);
`else
            r_cnt <= r_cnt + CW'(1);
`endif
        end
    end

endmodule

// File: rtl/cochlea_event_scanner.sv
// Multi-channel spike event scanner with a Wishbone slave register bank.
// Counts rising edges per channel over a programmable window, latches the
// counts into RESULT registers and raises a level interrupt at window end.
// Optional macro COCHLEA_CNT_SAT_EN: counters saturate instead of wrapping.
module cochlea_event_scanner #(
    parameter int          NCH      = 16,
    parameter int          CW       = 16,
    parameter int          WW       = 24,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           wbs_stb_i,
    input  logic           wbs_cyc_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic           wbs_ack_o,
    output logic [31:0]    wbs_dat_o,
    input  logic [NCH-1:0] chan_in,
    output logic           busy_o,
    output logic           irq_o
);
    import cochlea_scan_pkg::*;

    state_t                  r_state, w_nxt;
    logic                    r_ack;
    logic [31:0]             r_dat, w_rdat;
    logic                    r_cont, r_irq_en, r_done, r_ovf;
    logic [WW-1:0]           r_window, r_wcnt;
    logic [NCH-1:0]          r_mask;
    logic [NCH-1:0][CW-1:0]  r_result, w_live;
    logic [NCH-1:0]          w_ovf;
    logic                    w_acc, w_go, w_wr, w_ctrl_wr, w_stat_wr, w_start, w_abort;
    logic                    w_clr, w_load, w_latch, w_run;
    logic [7:0]              w_off;
    logic                    w_unused;

    assign w_acc     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign w_go      = w_acc & ~r_ack;
    assign w_wr      = w_go & wbs_we_i;
    assign w_off     = {wbs_adr_i[7:2], 2'b00};
    assign w_ctrl_wr = w_wr & (w_off == REG_CTRL) & wbs_sel_i[0];
    assign w_stat_wr = w_wr & (w_off == REG_STATUS);
    assign w_start   = w_ctrl_wr & wbs_dat_i[CTRL_START];
    assign w_abort   = w_ctrl_wr & wbs_dat_i[CTRL_ABORT];
    assign w_run     = (r_state == ST_RUN);
    assign w_unused  = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i};

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign busy_o    = (r_state != ST_IDLE);
    assign irq_o     = r_done & r_irq_en;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            cochlea_chan_counter #(.CW(CW)) u_chan (
                .i_clk   (wb_clk_i),
                .i_rst   (wb_rst_i),
                .i_spike (chan_in[g]),
                .i_clr   (w_clr),
                .i_en    (w_run & r_mask[g]),
                .o_cnt   (w_live[g]),
                .o_ovf   (w_ovf[g])
            );
        end
    endgenerate

    // Window FSM state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_nxt;
    end

    // Next state plus clear/reload/latch strobes; ABORT overrides everything.
    always_comb begin
        w_nxt   = r_state;
        w_clr   = 1'b0;
        w_load  = 1'b0;
        w_latch = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start) begin
                w_nxt  = ST_RUN;
                w_clr  = 1'b1;
                w_load = 1'b1;
            end
            ST_RUN: if (r_wcnt == '0) w_nxt = ST_LATCH;
            ST_LATCH: begin
                w_latch = 1'b1;
                w_clr   = 1'b1;
                if (r_cont) begin
                    w_nxt  = ST_RUN;
                    w_load = 1'b1;
                end else begin
                    w_nxt = ST_IDLE;
                end
            end
            default: w_nxt = ST_IDLE;
        endcase
        if (w_abort) begin
            w_nxt   = ST_IDLE;
            w_latch = 1'b0;
            w_load  = 1'b0;
        end
    end

    // Window down-counter: a WINDOW of 0 behaves as 1 cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)                  r_wcnt <= '0;
        else if (w_load)               r_wcnt <= (r_window == '0) ? '0 : r_window - WW'(1);
        else if (w_run && r_wcnt != '0) r_wcnt <= r_wcnt - WW'(1);
    end

    // Control/config registers and sticky status; hardware set beats W1C.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cont   <= 1'b0;
            r_irq_en <= 1'b0;
            r_window <= '0;
            r_mask   <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_cont   <= wbs_dat_i[CTRL_CONT];
                r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            if (w_wr && w_off == REG_WINDOW) r_window <= wbs_dat_i[WW-1:0];
            if (w_wr && w_off == REG_MASK)   r_mask   <= wbs_dat_i[NCH-1:0];
            if (w_stat_wr && wbs_dat_i[STAT_DONE]) r_done <= 1'b0;
            if (w_stat_wr && wbs_dat_i[STAT_OVF])  r_ovf  <= 1'b0;
            if (w_latch) r_done <= 1'b1;
            if (|w_ovf)  r_ovf  <= 1'b1;
        end
    end

    // Readback bank captures the live counts at window end.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)     r_result <= '0;
        else if (w_latch) r_result <= w_live;
    end

    // Register read mux; unmapped offsets read 0.
    always_comb begin
        w_rdat = '0;
        case (w_off)
            REG_CTRL: begin
                w_rdat[CTRL_CONT]   = r_cont;
                w_rdat[CTRL_IRQ_EN] = r_irq_en;
            end
            REG_WINDOW: w_rdat[WW-1:0] = r_window;
            REG_STATUS: begin
                w_rdat[STAT_BUSY] = busy_o;
                w_rdat[STAT_DONE] = r_done;
                w_rdat[STAT_OVF]  = r_ovf;
            end
            REG_MASK: w_rdat[NCH-1:0] = r_mask;
            default: begin
                for (int i = 0; i < NCH; i++)
                    if (w_off == REG_RESULT_BASE + 8'(4 * i)) w_rdat[CW-1:0] = r_result[i];
            end
        endcase
    end

    // Single-cycle ack one cycle after the access; never on consecutive cycles.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_go;
            r_dat <= (w_go && !wbs_we_i) ? w_rdat : '0;
        end
    end

endmodule

// File: tb/tb_cochlea_event_scanner.sv
// Self-checking bench: two scanners (CW=16 and CW=4) share one bus and the
// same spike inputs. Expected counts come from counting 0->1 transitions of
// the driven spike pattern, then applying mask and counter width rules.
module tb_cochlea_event_scanner;
    localparam int NCH = 16;
    localparam logic [31:0] B = 32'h3000_0000;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic stb = 0, cyc = 0, we = 0;
    logic [3:0] sel = 0;
    logic [31:0] adr = 0, wdat = 0;
    logic [NCH-1:0] chan = '0;
    logic ack16, ack4, busy16, busy4, irq16, irq4;
    logic [31:0] dat16, dat4;

    cochlea_event_scanner #(.NCH(NCH), .CW(16), .WW(24), .BASE_ADR(B)) u_dut16 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack16), .wbs_dat_o(dat16),
        .chan_in(chan), .busy_o(busy16), .irq_o(irq16));

    cochlea_event_scanner #(.NCH(NCH), .CW(4), .WW(24), .BASE_ADR(B)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack4), .wbs_dat_o(dat4),
        .chan_in(chan), .busy_o(busy4), .irq_o(irq4));

    int n_chk = 0, n_fail = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int edges[NCH];
    logic [NCH-1:0] drv_prev = '0;
    int e16[NCH], e4[NCH];
    logic exp_ovf4;
    int commit_cyc;
    logic [NCH-1:0] cur_mask;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] e;
    } vec_t;
    vec_t tbl[14];

    function automatic int cap4(int n);
`ifdef COCHLEA_CNT_SAT_EN
        return (n > 15) ? 15 : n;
`else
        return n % 16;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r16, output logic [31:0] r4);
        @(posedge clk); #1;
        chk("ack_idle", {31'b0, ack16 | ack4}, 0);
        stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
        @(posedge clk); #1;
        commit_cyc = cyc_n;
        chk("ack16", {31'b0, ack16}, 1);
        chk("ack4", {31'b0, ack4}, 1);
        r16 = dat16; r4 = dat4;
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] x, y;
        bus(1'b1, a, d, s, x, y);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] x16, input logic [31:0] x4);
        logic [31:0] r16, r4;
        bus(1'b0, a, 0, 4'h0, r16, r4);
        chk({nm, "_16"}, r16, x16);
        chk({nm, "_4"}, r4, x4);
    endtask

    task automatic stim(input int mode, input int len);
        logic [NCH-1:0] v;
        for (int c = 0; c < len; c++) begin
            case (mode)
                1: v = ((c % 8) < 4) ? NCH'(8) : '0;
                2: v = ((c % 4) < 2) ? NCH'(3) : '0;
                3: v = ((c % 4) < 2) ? NCH'(1) : '0;
                4: v = NCH'($urandom);
                default: v = '0;
            endcase
            for (int i = 0; i < NCH; i++) if (v[i] && !drv_prev[i]) edges[i]++;
            drv_prev = v;
            chan = v;
            @(posedge clk); #1;
        end
        chan = '0;
        drv_prev = '0;
    endtask

    task automatic clr_edges();
        for (int i = 0; i < NCH; i++) edges[i] = 0;
    endtask

    task automatic model_window(input logic [NCH-1:0] m);
        exp_ovf4 = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            e16[i] = m[i] ? edges[i] : 0;
            e4[i]  = cap4(e16[i]);
            if (e16[i] > 15) exp_ovf4 = 1'b1;
        end
    endtask

    task automatic check_results(input string nm);
        for (int i = 0; i < NCH; i++)
            rd_chk($sformatf("%s_res%0d", nm, i), B + 32'h40 + 32'(4 * i), 32'(e16[i]), 32'(e4[i]));
    endtask

    task automatic wait_irq(input int bound, output int c);
        c = -1;
        for (int k = 0; k < bound; k++) begin
            @(posedge clk); #1;
            if (irq16) begin
                c = cyc_n;
                break;
            end
        end
    endtask

    task automatic run_win(input string nm, input int w, input logic [NCH-1:0] m, input int mode, input int len);
        int c0, c;
        wr(B + 32'h04, 32'(w), 4'hF);
        wr(B + 32'h0C, 32'(m), 4'hF);
        cur_mask = m;
        clr_edges();
        wr(B + 32'h00, 32'h5, 4'h1);
        c0 = commit_cyc;
        chk({nm, "_busy"}, {31'b0, busy16 & busy4}, 1);
        stim(mode, len);
        wait_irq(w + 50, c);
        chk({nm, "_irq_lat"}, 32'(c - c0), 32'(w + 1));
        chk({nm, "_irq4"}, {31'b0, irq4}, 1);
        model_window(m);
        check_results(nm);
        rd_chk({nm, "_status"}, B + 32'h08, 32'h2, 32'h2 | {29'b0, exp_ovf4, 2'b0});
        wr(B + 32'h08, 32'h6, 4'hF);
        chk({nm, "_irq_clr"}, {31'b0, irq16 | irq4}, 0);
        rd_chk({nm, "_status_clr"}, B + 32'h08, 0, 0);
    endtask

    initial begin
        int c, c0;
        tbl[0]  = '{1'b0, B + 32'h00, 32'h0, 4'h0, 32'h0};
        tbl[1]  = '{1'b0, B + 32'h04, 32'h0, 4'h0, 32'h0};
        tbl[2]  = '{1'b0, B + 32'h08, 32'h0, 4'h0, 32'h0};
        tbl[3]  = '{1'b0, B + 32'h0C, 32'h0, 4'h0, 32'h0};
        tbl[4]  = '{1'b0, B + 32'h40, 32'h0, 4'h0, 32'h0};
        tbl[5]  = '{1'b0, B + 32'h7C, 32'h0, 4'h0, 32'h0};
        tbl[6]  = '{1'b0, B + 32'h80, 32'h0, 4'h0, 32'h0};
        tbl[7]  = '{1'b1, B + 32'h04, 32'h0123_4567, 4'hF, 32'h0023_4567};
        tbl[8]  = '{1'b1, B + 32'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0000_FFFF};
        tbl[9]  = '{1'b1, B + 32'h00, 32'h6, 4'h1, 32'h6};
        tbl[10] = '{1'b1, B + 32'h00, 32'h0, 4'h0, 32'h6};
        tbl[11] = '{1'b1, B + 32'h00, 32'h0, 4'h1, 32'h0};
        tbl[12] = '{1'b1, B + 32'h08, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[13] = '{1'b1, B + 32'h44, 32'hFFFF_FFFF, 4'hF, 32'h0};
        clr_edges();

        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_ack", {31'b0, ack16 | ack4}, 0);
        chk("rst_dat", dat16 | dat4, 0);
        chk("rst_busy", {31'b0, busy16 | busy4}, 0);
        chk("rst_irq", {31'b0, irq16 | irq4}, 0);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) wr(tbl[i].a, tbl[i].d, tbl[i].s);
            rd_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].e, tbl[i].e);
        end

        // Held strobe acks every other cycle.
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 0; adr = B + 32'h0C;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("ack_held", {31'b0, ack16}, 32'(k % 2 == 0));
        end
        // Address outside the slave's page is never acknowledged.
        adr = B + 32'h100;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("ack_undecoded", {31'b0, ack16 | ack4}, 0);
        end
        stb = 0; cyc = 0;

        run_win("A", 100, 16'hFFFF, 1, 80);
        run_win("B", 100, 16'h0001, 2, 20);
        run_win("C", 100, 16'h0001, 3, 80);
        for (int r = 0; r < 3; r++)
            run_win($sformatf("R%0d", r), 150, NCH'($urandom), 4, 100);

        // ABORT mid-run leaves previous results and done untouched.
        wr(B + 32'h04, 32'd1000, 4'hF);
        wr(B + 32'h00, 32'h5, 4'h1);
        stim(4, 30);
        wr(B + 32'h00, 32'h8, 4'h1);
        chk("abort_busy", {31'b0, busy16 | busy4}, 0);
        check_results("abort");
        rd_chk("abort_status", B + 32'h08, 0, 0);

        // START while busy does not restart the window.
        wr(B + 32'h04, 32'd300, 4'hF);
        clr_edges();
        wr(B + 32'h00, 32'h5, 4'h1);
        c0 = commit_cyc;
        repeat (50) @(posedge clk);
        #1;
        wr(B + 32'h00, 32'h5, 4'h1);
        wait_irq(400, c);
        chk("restart_ignored", 32'(c - c0), 32'd301);
        model_window(cur_mask);
        check_results("sb");
        wr(B + 32'h08, 32'h6, 4'hF);

        // Continuous mode with WINDOW=0: a LATCH every second cycle.
        wr(B + 32'h04, 32'd0, 4'hF);
        wr(B + 32'h00, 32'h7, 4'h1);
        c0 = commit_cyc;
        wait_irq(10, c);
        chk("cont_first", 32'(c - c0), 32'd2);
        for (int k = 0; k < 3; k++) begin
            wr(B + 32'h08, 32'h2, 4'hF);
            c0 = commit_cyc;
            wait_irq(4, c);
            chk("cont_relatch", 32'(c - c0), 32'd1);
            chk("cont_busy", {31'b0, busy16 & busy4}, 1);
        end
        wr(B + 32'h00, 32'h8, 4'h1);
        chk("cont_abort_busy", {31'b0, busy16 | busy4}, 0);
        wr(B + 32'h08, 32'h6, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        chk("cont_abort_irq", {31'b0, irq16 | irq4}, 0);
        model_window(cur_mask);
        check_results("cont");

        // Reset in the middle of a window with spikes present.
        wr(B + 32'h04, 32'd500, 4'hF);
        wr(B + 32'h00, 32'h5, 4'h1);
        stim(4, 40);
        rst = 1;
        chan = NCH'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chan = '0;
        chk("rstrun_busy", {31'b0, busy16 | busy4}, 0);
        chk("rstrun_irq", {31'b0, irq16 | irq4}, 0);
        clr_edges();
        model_window(cur_mask);
        check_results("rstrun");
        rd_chk("rstrun_status", B + 32'h08, 0, 0);
        rd_chk("rstrun_ctrl", B + 32'h00, 0, 0);
        rd_chk("rstrun_mask", B + 32'h0C, 0, 0);
        wait_irq(520, c);
        chk("rstrun_no_latch", 32'(c), 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cochlea_event_scanner.md
Name: cochlea_event_scanner

Overview:
- Multi-channel digital back-end for the cochlea filterbank; generalises the single analog-example hookup to NCH parametrised channel comparator outputs.
- Synchronises each channel's 1-bit spike input and counts rising edges per channel over a programmable window.
- Latches results into a readback bank and raises an interrupt at window end.
- Sits in user_analog_project_wrapper between io_in/gpio spike pads and the Wishbone slave port.

Parameters:
- NCH, 16, number of spike channels (1..32).
- CW, 16, per-channel count width (4..32).
- WW, 24, window-length register width.
- BASE_ADR, 32'h3000_0000, Wishbone base address; decode uses adr[31:8].

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- chan_in  in  NCH  asynchronous spike inputs from comparators
- busy_o  out  1  window running (for LA)
- irq_o  out  1  window-done interrupt level

Behaviour:
- Reset: all outputs 0; every register 0; FSM in IDLE.
- Inputs: 2-flop synchroniser per channel, then an edge register. An event is sync=1 and prev=0.
- Registers (offset, 32-bit; sel ignored on write except CTRL):
  - 0x00 CTRL: b0 START (self-clearing), b1 CONT, b2 IRQ_EN, b3 ABORT (self-clearing).
  - 0x04 WINDOW[WW-1:0].
  - 0x08 STATUS: b0 busy (RO), b1 done (W1C), b2 ovf (W1C).
  - 0x0C MASK[NCH-1:0]; 1 = channel counted.
  - 0x40+4*i: RESULT[i] (RO, zero-extended). Unused or out-of-range reads return 0.
- Wishbone:
  - Access is stb&cyc with adr[31:8]==BASE_ADR[31:8].
  - ack_o is asserted one cycle after the access is seen, for exactly one cycle; no wait states.
  - ack is never asserted on back-to-back cycles; a held strobe acks every other cycle.
  - dat_o is valid with ack and is 0 otherwise.
- FSM states: IDLE, RUN, LATCH.
  - IDLE→RUN on START: clear live counters; load wcnt=max(WINDOW,1)-1.
  - RUN: each cycle, increment the live counter of every masked channel that has an event; decrement wcnt. When wcnt==0 and the cycle is counted, go to LATCH.
  - LATCH (1 cycle): RESULT[i]←live[i] for all i; done←1; then, if CONT, go to RUN with counters cleared and wcnt reloaded, otherwise go to IDLE.
  - Window length is exactly max(WINDOW,1) RUN cycles. Events in the LATCH cycle are dropped.
- Counter overflow: default wrap modulo 2^CW. Any wrap sets ovf sticky.
- irq_o = done & IRQ_EN (level); cleared by W1C of done.
- Simultaneous events:
  - W1C of done in the same cycle as LATCH: set wins.
  - START while busy: ignored.
  - ABORT: any state→IDLE next cycle; RESULT keeps its old values; done unchanged.
  - WINDOW or MASK writes mid-RUN: MASK takes effect next cycle; WINDOW takes effect at the next reload.
- Reset mid-window: everything is cleared and no LATCH occurs.
- busy_o = (state != IDLE).

Optional Feature:
- COCHLEA_CNT_SAT_EN defined: live counters saturate at 2^CW-1 instead of wrapping. ovf is set when a channel first saturates.
- Undefined: wrap behaviour as above.

Decomposition:
- Package cochlea_scan_pkg holds:
  - the register offset localparams (CTRL, WINDOW, STATUS, MASK, RESULT_BASE);
  - CTRL/STATUS bit indices;
  - the FSM state enum (2-bit).
- One sub-module, cochlea_chan_counter: synchroniser + edge detect + CW-bit counter, with clear/enable/saturate. Generated NCH times.

Test Plan:
- Reset, then read all registers → every register 0; ack exactly one cycle after each strobe; irq_o=0.
- NCH=16, WINDOW=100, MASK=0xFFFF, IRQ_EN=1, START; drive ch3 with 10 pulses (4 high/4 low) inside the window → RESULT[3]=10, other results 0; done=1, irq_o=1 at cycle 101 after START; W1C clears irq.
- MASK=0x0001, pulse ch0 and ch1 5 times each → RESULT[0]=5, RESULT[1]=0.
- CW=4, 20 pulses on ch0 → without macro RESULT[0]=4 and ovf=1; with COCHLEA_CNT_SAT_EN, RESULT[0]=15 and ovf=1.
- CONT=1, WINDOW=0 → LATCH every 2 cycles; an ABORT mid-run → IDLE next cycle, RESULT unchanged; START while busy → no restart.
- Assert wb_rst_i during RUN with pending events → busy_o=0, RESULT all 0, no irq.
